// File: rtl/dwt_mac_sched.sv
// dwt_mac_sched: arbitrates four DWT level requesters onto one shared FP32 MAC
// and routes results back by owner tag. Define DWT_SCHED_RR_EN for round-robin.
module dwt_mac_sched #(
    parameter int MAC_LAT   = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic         clk_312_5,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] req_op_a,
    input  logic [127:0] req_op_b,
    input  logic [3:0]   req_last,
    output logic [3:0]   gnt,
    output logic         mac_valid,
    output logic         mac_clr,
    output logic         mac_last,
    output logic [31:0]  mac_a,
    output logic [31:0]  mac_b,
    input  logic [31:0]  mac_res,
    input  logic         mac_res_valid,
    output logic [31:0]  res_data,
    output logic [3:0]   res_valid,
    output logic         busy,
    output logic         err_tag
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    // The MAC pipeline depth is opaque here; results are matched purely by order.
    if (MAC_LAT < 1) begin : g_mac_lat_nonpositive
    end

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic          first_q, first_d;

    logic [1:0]    tag_mem_q [TAG_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mac_valid_q, mac_clr_q, mac_last_q;
    logic [31:0]   mac_a_q, mac_b_q;
    logic [31:0]   res_data_q;
    logic [3:0]    res_valid_q;
    logic          err_q;

    logic          accept, start, push, pop, full;
    logic [1:0]    win, head;

    assign full   = (cnt_q == CW'(TAG_DEPTH));
    assign head   = tag_mem_q[rptr_q];
    assign accept = (state_q == S_BURST) && req[owner_q];
    assign pop    = mac_res_valid && (cnt_q != '0);
    assign start  = (state_q == S_IDLE) && (|req) && !full;

`ifdef DWT_SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) win = idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (start) ptr_d = win + 2'd1;
    end

    always_ff @(posedge clk_312_5) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) win = 2'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        first_d = first_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BURST;
                    owner_d = win;
                    first_d = 1'b1;
                end
            end
            S_BURST: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (req_last[owner_q]) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_312_5) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 2'd0;
            first_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            first_q <= first_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk_312_5) begin
        if (push) tag_mem_q[wptr_q] <= owner_q;
    end

    always_ff @(posedge clk_312_5) begin
        if (rst) begin
            mac_valid_q <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mac_valid_q <= accept;
            mac_clr_q   <= accept && first_q;
            mac_last_q  <= accept && req_last[owner_q];
            if (accept) begin
                mac_a_q <= req_op_a[{owner_q, 5'd0} +: 32];
                mac_b_q <= req_op_b[{owner_q, 5'd0} +: 32];
            end
            if (pop) res_data_q <= mac_res;
            res_valid_q <= pop ? (4'b0001 << head) : 4'b0000;
            if (mac_res_valid && (cnt_q == '0)) err_q <= 1'b1;
        end
    end

    assign gnt       = (state_q == S_BURST) ? (req & (4'b0001 << owner_q)) : 4'b0000;
    assign mac_valid = mac_valid_q;
    assign mac_clr   = mac_clr_q;
    assign mac_last  = mac_last_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == S_BURST) || (cnt_q != '0);
    assign err_tag   = err_q;

endmodule

// File: tb/tb_dwt_mac_sched.sv
// Directed table-driven bench for dwt_mac_sched plus hand-written
// reset/error sequences.
module tb_dwt_mac_sched;

    logic         clk_312_5 = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_op_a;
    logic [127:0] req_op_b;
    logic [3:0]   req_last;
    logic [3:0]   gnt;
    logic         mac_valid, mac_clr, mac_last;
    logic [31:0]  mac_a, mac_b;
    logic [31:0]  mac_res;
    logic         mac_res_valid;
    logic [31:0]  res_data;
    logic [3:0]   res_valid;
    logic         busy, err_tag;

    always #5 clk_312_5 = ~clk_312_5;

    dwt_mac_sched #(.MAC_LAT(8), .TAG_DEPTH(4)) dut (
        .clk_312_5     (clk_312_5),
        .rst           (rst),
        .req           (req),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .req_last      (req_last),
        .gnt           (gnt),
        .mac_valid     (mac_valid),
        .mac_clr       (mac_clr),
        .mac_last      (mac_last),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_res       (mac_res),
        .mac_res_valid (mac_res_valid),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .busy          (busy),
        .err_tag       (err_tag)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        rv;
        logic [31:0] res;
        logic [3:0]  gnt;
        logic        busy;
        logic        mv;
        logic        clr;
        logic        ml;
        logic [1:0]  own;
        logic [3:0]  resv;
        logic        err;
    } vec_t;

    vec_t       tbl[$];
    logic [1:0] own [5];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic [3:0] rq, input logic [3:0] lt,
        input logic rv, input logic [31:0] res,
        input logic [3:0] g, input logic b,
        input logic mv, input logic cl, input logic ml,
        input logic [1:0] ow, input logic [3:0] rsv, input logic er);
        vec_t v;
        v.rst = r;   v.req = rq;  v.last = lt; v.rv = rv;  v.res = res;
        v.gnt = g;   v.busy = b;  v.mv = mv;   v.clr = cl; v.ml = ml;
        v.own = ow;  v.resv = rsv; v.err = er;
        return v;
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] o);
        return 4'b0001 << o;
    endfunction

    task automatic apply(input int i, input vec_t v);
        logic [31:0] ea, eb;
        rst           = v.rst;
        req           = v.req;
        req_last      = v.last;
        mac_res_valid = v.rv;
        mac_res       = v.res;
        for (int k = 0; k < 4; k++) begin
            req_op_a[32*k +: 32] = {4'hA, 4'(k), 8'h00, 16'(i)};
            req_op_b[32*k +: 32] = {4'hB, 4'(k), 8'h00, 16'(i)};
        end
        #1;
        chk($sformatf("v%0d gnt", i), {28'h0, gnt}, {28'h0, v.gnt});
        chk($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, v.busy});
        @(posedge clk_312_5);
        #1;
        chk($sformatf("v%0d mac_valid", i), {31'h0, mac_valid}, {31'h0, v.mv});
        chk($sformatf("v%0d mac_clr", i), {31'h0, mac_clr}, {31'h0, v.clr});
        chk($sformatf("v%0d mac_last", i), {31'h0, mac_last}, {31'h0, v.ml});
        chk($sformatf("v%0d res_valid", i), {28'h0, res_valid}, {28'h0, v.resv});
        chk($sformatf("v%0d err_tag", i), {31'h0, err_tag}, {31'h0, v.err});
        if (v.mv) begin
            ea = {4'hA, 2'b00, v.own, 8'h00, 16'(i)};
            eb = {4'hB, 2'b00, v.own, 8'h00, 16'(i)};
            chk($sformatf("v%0d mac_a", i), mac_a, ea);
            chk($sformatf("v%0d mac_b", i), mac_b, eb);
        end
        if (v.resv != 4'h0) chk($sformatf("v%0d res_data", i), res_data, v.res);
        if (v.rst) begin
            chk($sformatf("v%0d rst mac_a", i), mac_a, 32'h0);
            chk($sformatf("v%0d rst res_data", i), res_data, 32'h0);
        end
        @(negedge clk_312_5);
    endtask

    initial begin
`ifdef DWT_SCHED_RR_EN
        own[0] = 2'd0; own[1] = 2'd1; own[2] = 2'd2; own[3] = 2'd3; own[4] = 2'd0;
`else
        own[0] = 2'd0; own[1] = 2'd0; own[2] = 2'd0; own[3] = 2'd0; own[4] = 2'd0;
`endif
        // single 8-tap burst from L1, then its result
        tbl.push_back(mk(1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        for (int t = 1; t <= 7; t++)
            tbl.push_back(mk(1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 4'h1, 1'b1, 1'b1, (t == 1), 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 4'h1, 1'b0, 32'h0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b1, 32'h3F80_0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        // L3 burst with a 3-cycle stall while others request
        tbl.push_back(mk(1'b0, 4'h4, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h4, 4'h0, 1'b0, 32'h0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0));
        for (int t = 0; t < 3; t++)
            tbl.push_back(mk(1'b0, 4'hB, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 1'b0, 32'h0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h4, 4'h4, 1'b0, 32'h0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0));
        // issue order 2,0 then 1 with push and pop in the same cycle
        tbl.push_back(mk(1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 4'h1, 1'b0, 32'h0, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b1, 32'h1111_1111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 1'b0));
        tbl.push_back(mk(1'b0, 4'h2, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h2, 4'h2, 1'b1, 32'h2222_2222, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'h1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b1, 32'h3333_3333, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h2, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        // reset, then contention with 2-tap bursts until the tag FIFO fills
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        for (int b = 0; b < 4; b++) begin
            tbl.push_back(mk(1'b0, 4'hF, 4'h0, 1'b0, 32'h0, 4'h0, (b != 0), 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
            tbl.push_back(mk(1'b0, 4'hF, 4'h0, 1'b0, 32'h0, oh(own[b]), 1'b1, 1'b1, 1'b1, 1'b0, own[b], 4'h0, 1'b0));
            tbl.push_back(mk(1'b0, 4'hF, 4'hF, 1'b0, 32'h0, oh(own[b]), 1'b1, 1'b1, 1'b0, 1'b1, own[b], 4'h0, 1'b0));
        end
        for (int t = 0; t < 2; t++)
            tbl.push_back(mk(1'b0, 4'hF, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 1'b1, 32'hC0DE_0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, oh(own[0]), 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, 4'hF, 1'b0, 32'h0, oh(own[4]), 1'b1, 1'b1, 1'b1, 1'b1, own[4], 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        for (int b = 1; b <= 4; b++)
            tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b1, 32'hC0DE_0000 + 32'(b), 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, oh(own[b]), 1'b0));
        // result with nothing outstanding
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1));

        rst = 1'b1; req = 4'h0; req_last = 4'h0; mac_res_valid = 1'b0;
        mac_res = 32'h0; req_op_a = '0; req_op_b = '0;
        repeat (2) @(posedge clk_312_5);
        #1;
        chk("rst gnt", {28'h0, gnt}, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst mac_valid", {31'h0, mac_valid}, 32'h0);
        chk("rst res_valid", {28'h0, res_valid}, 32'h0);
        chk("rst err_tag", {31'h0, err_tag}, 32'h0);
        chk("rst mac_a", mac_a, 32'h0);
        chk("rst res_data", res_data, 32'h0);
        @(negedge clk_312_5);
        rst = 1'b0;

        foreach (tbl[i]) apply(i, tbl[i]);

        // reset in the middle of a burst
        req = 4'h1; req_last = 4'h0; mac_res_valid = 1'b0;
        @(posedge clk_312_5);
        @(negedge clk_312_5);
        chk("mid gnt before rst", {28'h0, gnt}, 32'h1);
        @(posedge clk_312_5);
        #1;
        chk("mid tap accepted", {31'h0, mac_valid}, 32'h1);
        @(negedge clk_312_5);
        rst = 1'b1;
        @(posedge clk_312_5);
        #1;
        chk("mid rst gnt", {28'h0, gnt}, 32'h0);
        chk("mid rst busy", {31'h0, busy}, 32'h0);
        chk("mid rst mac_valid", {31'h0, mac_valid}, 32'h0);
        chk("mid rst err_tag", {31'h0, err_tag}, 32'h0);
        @(negedge clk_312_5);
        rst = 1'b0; req = 4'h0; mac_res_valid = 1'b1; mac_res = 32'h4040_0000;
        @(posedge clk_312_5);
        #1;
        chk("late res err_tag", {31'h0, err_tag}, 32'h1);
        chk("late res res_valid", {28'h0, res_valid}, 32'h0);
        @(negedge clk_312_5);
        mac_res_valid = 1'b0;
        repeat (3) @(posedge clk_312_5);
        #1;
        chk("err_tag sticky", {31'h0, err_tag}, 32'h1);
        chk("idle after rst", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
